// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit engine between NUM_REQ byte sources.
// Engine status comes from the slow baud domain and is edge-detected on clk.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   i_Req_Valid,
    input  logic [NUM_REQ*8-1:0] i_Req_Byte,
    output logic [NUM_REQ-1:0]   o_Req_Ack,
    output logic [7:0]           o_Tx_Byte,
    output logic                 o_Tx_Ready,
    input  logic                 i_Tx_Active,
    input  logic                 i_Tx_Done,
    output logic [NUM_REQ-1:0]   o_Grant,
    output logic                 o_Busy,
    output logic                 o_Timeout
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t            state;
    logic [PTR_W-1:0]  ptr;
    logic [CNT_W-1:0]  cnt;
    logic              act_q;
    logic              done_q;

    logic              win_found_c;
    logic [PTR_W-1:0]  win_idx_c;
    logic [PTR_W-1:0]  ptr_next_c;
    logic [7:0]        win_byte_c;
    logic [CNT_W-1:0]  cnt_next_c;
    logic              timeout_hit_c;
    logic              act_rise_c;
    logic              act_fall_c;
    logic              done_rise_c;

    // Scan requesters starting at the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        int unsigned j;
        j           = 0;
        win_found_c = 1'b0;
        win_idx_c   = ptr;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            j = 32'(ptr) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!win_found_c && i_Req_Valid[PTR_W'(j)]) begin
                win_found_c = 1'b1;
                win_idx_c   = PTR_W'(j);
            end
        end
    end

    assign ptr_next_c    = (win_idx_c == PTR_LAST) ? '0 : win_idx_c + PTR_W'(1);
    assign win_byte_c    = i_Req_Byte[{win_idx_c, 3'b000} +: 8];
    assign cnt_next_c    = cnt + CNT_W'(1);
    assign timeout_hit_c = (cnt_next_c == CNT_LAST);
    assign act_rise_c    = i_Tx_Active & ~act_q;
    assign act_fall_c    = ~i_Tx_Active & act_q;
    assign done_rise_c   = i_Tx_Done & ~done_q;

    // Frame FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            cnt        <= '0;
            act_q      <= 1'b0;
            done_q     <= 1'b0;
            o_Req_Ack  <= '0;
            o_Tx_Byte  <= '0;
            o_Tx_Ready <= 1'b0;
            o_Grant    <= '0;
            o_Busy     <= 1'b0;
            o_Timeout  <= 1'b0;
        end else begin
            act_q     <= i_Tx_Active;
            done_q    <= i_Tx_Done;
            o_Req_Ack <= '0;
            o_Timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found_c) begin
                        o_Tx_Byte  <= win_byte_c;
                        o_Req_Ack  <= NUM_REQ'(1) << win_idx_c;
                        o_Grant    <= NUM_REQ'(1) << win_idx_c;
                        o_Tx_Ready <= 1'b1;
                        o_Busy     <= 1'b1;
                        ptr        <= ptr_next_c;
                        cnt        <= '0;
                        state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (act_rise_c) begin
                        o_Tx_Ready <= 1'b0;
                        cnt        <= '0;
                        state      <= WAIT_DONE;
                    end else if (timeout_hit_c) begin
                        // Engine never started: drop the byte, no retry.
                        o_Timeout  <= 1'b1;
                        o_Tx_Ready <= 1'b0;
                        o_Grant    <= '0;
                        o_Busy     <= 1'b0;
                        cnt        <= '0;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt_next_c;
                    end
                end
                WAIT_DONE: begin
                    if (done_rise_c || act_fall_c) begin
                        o_Grant <= '0;
                        o_Busy  <= 1'b0;
                        cnt     <= '0;
                        state   <= IDLE;
                    end else if (timeout_hit_c) begin
                        o_Timeout <= 1'b1;
                        o_Grant   <= '0;
                        o_Busy    <= 1'b0;
                        cnt       <= '0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt_next_c;
                    end
                end
                default: begin
                    o_Tx_Ready <= 1'b0;
                    o_Grant    <= '0;
                    o_Busy     <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a 4-requester instance and a 3-requester
// instance with a short timeout.
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic [3:0]  a_valid;
    logic [31:0] a_bytes;
    logic [3:0]  a_ack, a_grant;
    logic [7:0]  a_txb;
    logic        a_ready, a_active, a_done, a_busy, a_to;

    logic [2:0]  b_valid;
    logic [23:0] b_bytes;
    logic [2:0]  b_ack, b_grant;
    logic [7:0]  b_txb;
    logic        b_ready, b_active, b_done, b_busy, b_to;

    uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(64)) u_a (
        .clk(clk), .reset(reset),
        .i_Req_Valid(a_valid), .i_Req_Byte(a_bytes), .o_Req_Ack(a_ack),
        .o_Tx_Byte(a_txb), .o_Tx_Ready(a_ready),
        .i_Tx_Active(a_active), .i_Tx_Done(a_done),
        .o_Grant(a_grant), .o_Busy(a_busy), .o_Timeout(a_to)
    );

    uart_tx_arbiter #(.NUM_REQ(3), .TIMEOUT_CYCLES(8)) u_b (
        .clk(clk), .reset(reset),
        .i_Req_Valid(b_valid), .i_Req_Byte(b_bytes), .o_Req_Ack(b_ack),
        .o_Tx_Byte(b_txb), .o_Tx_Ready(b_ready),
        .i_Tx_Active(b_active), .i_Tx_Done(b_done),
        .o_Grant(b_grant), .o_Busy(b_busy), .o_Timeout(b_to)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        int         idx;
        logic [7:0] b;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input int idx, input logic [7:0] b);
        exp_t e;
        e.idx = idx;
        e.b   = b;
        qa.push_back(e);
    endtask

    task automatic push_b(input int idx, input logic [7:0] b);
        exp_t e;
        e.idx = idx;
        e.b   = b;
        qb.push_back(e);
    endtask

    // Monitor: every ack pulse pops one expected capture.
    always @(negedge clk) begin
        exp_t e;
        if (a_ack != '0) begin
            if (qa.size() == 0) begin
                check("a_unexpected_ack", 32'(a_ack), 32'h0);
            end else begin
                e = qa.pop_front();
                check("a_ack", 32'(a_ack), 32'(4'(1) << e.idx));
                check("a_byte", 32'(a_txb), 32'(e.b));
                check("a_grant_at_ack", 32'(a_grant), 32'(4'(1) << e.idx));
                check("a_ready_at_ack", 32'(a_ready), 32'h1);
            end
        end
        if (b_ack != '0) begin
            if (qb.size() == 0) begin
                check("b_unexpected_ack", 32'(b_ack), 32'h0);
            end else begin
                e = qb.pop_front();
                check("b_ack", 32'(b_ack), 32'(3'(1) << e.idx));
                check("b_byte", 32'(b_txb), 32'(e.b));
                check("b_grant_at_ack", 32'(b_grant), 32'(3'(1) << e.idx));
            end
        end
    end

    task automatic a_launch_wait(output int who, output int n);
        n   = 0;
        who = -1;
        while (a_ack == '0 && n < 20) begin
            tick();
            n++;
        end
        if (a_ack == '0) begin
            tests++;
            fails++;
            $display("FAIL a_ack_wait: no ack within %0d cycles", n);
            return;
        end
        for (int k = 0; k < 4; k++) if (a_ack[k]) who = k;
        a_valid[who] = 1'b0;
    endtask

    task automatic b_launch_wait(output int who, output int n);
        n   = 0;
        who = -1;
        while (b_ack == '0 && n < 20) begin
            tick();
            n++;
        end
        if (b_ack == '0) begin
            tests++;
            fails++;
            $display("FAIL b_ack_wait: no ack within %0d cycles", n);
            return;
        end
        for (int k = 0; k < 3; k++) if (b_ack[k]) who = k;
        b_valid[who] = 1'b0;
    endtask

    task automatic a_engine(input int delay);
        repeat (delay) tick();
        check("a_ready_held", 32'(a_ready), 32'h1);
        a_active = 1'b1;
        tick();
        check("a_ready_drop", 32'(a_ready), 32'h0);
        check("a_busy_wait", 32'(a_busy), 32'h1);
        repeat (2) tick();
        a_done = 1'b1;
        tick();
        check("a_grant_clear", 32'(a_grant), 32'h0);
        check("a_busy_clear", 32'(a_busy), 32'h0);
        a_done   = 1'b0;
        a_active = 1'b0;
        tick();
    endtask

    task automatic b_engine();
        repeat (2) tick();
        b_active = 1'b1;
        tick();
        check("b_ready_drop", 32'(b_ready), 32'h0);
        repeat (2) tick();
        b_done = 1'b1;
        tick();
        check("b_grant_clear", 32'(b_grant), 32'h0);
        b_done   = 1'b0;
        b_active = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int who, n;
        bit to_early;
        reset    = 1'b1;
        a_valid  = '0; a_bytes = '0; a_active = 1'b0; a_done = 1'b0;
        b_valid  = '0; b_bytes = '0; b_active = 1'b0; b_done = 1'b0;
        repeat (3) tick();
        check("rst_a_ack", 32'(a_ack), 32'h0);
        check("rst_a_ready", 32'(a_ready), 32'h0);
        check("rst_a_grant", 32'(a_grant), 32'h0);
        check("rst_a_busy", 32'(a_busy), 32'h0);
        check("rst_b_busy", 32'(b_busy), 32'h0);
        reset = 1'b0;
        tick();

        // Single request on requester 2.
        a_bytes[23:16] = 8'hA5;
        push_a(2, 8'hA5);
        a_valid[2] = 1'b1;
        a_launch_wait(who, n);
        check("t1_latency", 32'(n), 32'd1);
        check("t1_who", 32'(who), 32'd2);
        check("t1_busy", 32'(a_busy), 32'h1);
        a_engine(16);

        // Fairness with pointer at 3; requester 3 re-requests after its first ack.
        a_bytes = 32'h43_32_21_10;
        push_a(3, 8'h43); push_a(0, 8'h10); push_a(1, 8'h21); push_a(2, 8'h32);
        push_a(3, 8'h54);
        a_valid = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            a_launch_wait(who, n);
            if (f == 0) begin
                check("rr_first", 32'(who), 32'd3);
                a_bytes[31:24] = 8'h54;
                a_valid[3]     = 1'b1;
            end
            a_engine(3);
        end
        check("rr_valids_clear", 32'(a_valid), 32'h0);

        // Reset in WAIT_DONE, then scan restarts at 0.
        a_bytes[23:16] = 8'h99;
        push_a(2, 8'h99);
        a_valid[2] = 1'b1;
        a_launch_wait(who, n);
        tick();
        a_active = 1'b1;
        tick();
        check("rst_mid_ready", 32'(a_ready), 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_ack", 32'(a_ack), 32'h0);
        check("rst_mid_grant", 32'(a_grant), 32'h0);
        check("rst_mid_busy", 32'(a_busy), 32'h0);
        check("rst_mid_txb", 32'(a_txb), 32'h0);
        check("rst_mid_to", 32'(a_to), 32'h0);
        a_active = 1'b0;
        tick();
        a_bytes[15:8]  = 8'h61;
        a_bytes[31:24] = 8'h63;
        push_a(1, 8'h61); push_a(3, 8'h63);
        a_valid = 4'b1010;
        a_launch_wait(who, n);
        check("rst_scan_who", 32'(who), 32'd1);
        check("rst_scan_latency", 32'(n), 32'd1);
        a_engine(2);
        a_launch_wait(who, n);
        a_engine(2);

        // Engine already active when the frame launches: needs a fresh rising edge.
        a_active = 1'b1;
        tick();
        a_bytes[7:0] = 8'h3C;
        push_a(0, 8'h3C);
        a_valid[0] = 1'b1;
        a_launch_wait(who, n);
        repeat (4) tick();
        check("pre_ready_high", 32'(a_ready), 32'h1);
        check("pre_busy", 32'(a_busy), 32'h1);
        a_active = 1'b0;
        tick();
        check("pre_ready_after_fall", 32'(a_ready), 32'h1);
        check("pre_grant_after_fall", 32'(a_grant), 32'h1);
        a_active = 1'b1;
        tick();
        check("pre_ready_after_rise", 32'(a_ready), 32'h0);
        a_done = 1'b1;
        tick();
        check("pre_grant_clear", 32'(a_grant), 32'h0);
        a_done   = 1'b0;
        a_active = 1'b0;
        tick();

        // NUM_REQ=3 pointer wrap: grant 2, then {0,2} -> 0 first.
        b_bytes[23:16] = 8'h77;
        push_b(2, 8'h77);
        b_valid = 3'b100;
        b_launch_wait(who, n);
        check("wrap_first", 32'(who), 32'd2);
        b_bytes = 24'h22_00_11;
        push_b(0, 8'h11); push_b(2, 8'h22);
        b_valid = 3'b101;
        b_engine();
        b_launch_wait(who, n);
        check("wrap_to_zero", 32'(who), 32'd0);
        b_engine();
        b_launch_wait(who, n);
        b_engine();

        // Stalled engine: timeout pulse 7 cycles after LAUNCH entry.
        b_bytes[15:8] = 8'h5A;
        push_b(1, 8'h5A);
        b_valid = 3'b010;
        b_launch_wait(who, n);
        to_early = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (b_to) to_early = 1'b1;
        end
        check("to_not_early", 32'(to_early), 32'h0);
        tick();
        check("to_pulse", 32'(b_to), 32'h1);
        check("to_ready", 32'(b_ready), 32'h0);
        check("to_grant", 32'(b_grant), 32'h0);
        check("to_busy", 32'(b_busy), 32'h0);
        tick();
        check("to_one_cycle", 32'(b_to), 32'h0);
        b_bytes[23:16] = 8'hC3;
        push_b(2, 8'hC3);
        b_valid[2] = 1'b1;
        b_launch_wait(who, n);
        check("to_next_who", 32'(who), 32'd2);
        b_engine();

        repeat (3) tick();
        check("a_queue_drained", 32'(qa.size()), 32'h0);
        check("b_queue_drained", 32'(qb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmit engine between NUM_REQ byte sources using round-robin arbitration.
- Captures the winning requester's byte and presents it to the engine on a byte/ready interface.
- Tracks the frame from start (engine active) to completion (engine done), with a timeout for a stalled engine.
- Runs on the system clock. The engine runs on its baud tick clock, so all engine status inputs are edge-detected here.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 1048576, max clk cycles spent in LAUNCH or in WAIT_DONE before abort (>=4).
- PTR_W, $clog2(NUM_REQ), width of the round-robin pointer (derived, not overridden).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_Req_Valid  in  NUM_REQ  per-requester byte valid; held until matching ack
- i_Req_Byte  in  NUM_REQ*8  requester k byte at bits [8k+7:8k]
- o_Req_Ack  out  NUM_REQ  one-hot, one-cycle pulse when requester k's byte is captured
- o_Tx_Byte  out  8  byte presented to the UART transmit engine
- o_Tx_Ready  out  1  start request to engine; level, held until engine active is seen
- i_Tx_Active  in  1  engine busy flag (baud-clock domain, slow)
- i_Tx_Done  in  1  engine frame-done flag (baud-clock domain, slow)
- o_Grant  out  NUM_REQ  one-hot owner of the current frame; 0 when idle
- o_Busy  out  1  high in any state other than IDLE
- o_Timeout  out  1  one-cycle pulse on abort

Behaviour:
- Reset, synchronous: all outputs 0, state IDLE, pointer 0, timeout counter 0, active/done history registers 0. Reset mid-frame drops o_Tx_Ready the same edge; no ack is issued.
- States: IDLE, LAUNCH, WAIT_DONE.
- IDLE:
  - Winner = first k with valid[k]=1, searching ptr, ptr+1, … mod NUM_REQ.
  - At the next edge with any valid: o_Tx_Byte <= winner byte; o_Req_Ack[k]=1 for that one cycle; o_Grant <= onehot(k); o_Tx_Ready <= 1; ptr <= (k+1) mod NUM_REQ; counter <= 0; go to LAUNCH.
  - Latency from valid to ack is one cycle.
- LAUNCH:
  - Rising edge of i_Tx_Active (act_q=0, act=1) → o_Tx_Ready <= 0, counter <= 0, go to WAIT_DONE.
  - If i_Tx_Active is already 1 on entry, wait for it to fall and rise again. A rising edge is always required.
  - Otherwise counter increments. On reaching TIMEOUT_CYCLES-1: o_Timeout pulse, o_Tx_Ready <= 0, o_Grant <= 0, go to IDLE. The byte is dropped and not retried.
- WAIT_DONE:
  - Rising edge of i_Tx_Done, or falling edge of i_Tx_Active, whichever comes first → o_Grant <= 0, go to IDLE.
  - Same-cycle arrival of both edges counts once.
  - Same timeout rule as LAUNCH.
- Ack rules:
  - Only one ack per frame.
  - No new capture while o_Busy=1. New valids wait; they are never lost and never acked early.
  - A requester dropping valid before ack is a protocol violation. The arbiter simply does not select it.
- Back-to-back: IDLE lasts at least one cycle between frames. Minimum cycle is ack → next ack ≥ 3 cycles plus engine time.
- Pointer wraps NUM_REQ-1 → 0. Non-power-of-2 NUM_REQ must wrap correctly (e.g. 2 → 0 for NUM_REQ=3).
- Counter width is $clog2(TIMEOUT_CYCLES)+1; it must not wrap before the compare.
- o_Busy = (state != IDLE), registered.

Test Plan:
- Single request, NUM_REQ=4: valid[2]=1, byte2=0xA5 → next cycle ack=0100, o_Tx_Byte=0xA5, o_Tx_Ready=1, o_Grant=0100. Engine model raises active after 16 cycles → Ready drops. Done rises → Grant=0, Busy=0, ptr=3.
- Round-robin fairness: all four valids held, ptr=0 → acks in order 0,1,2,3,0, each byte delivered once with the correct value. No requester acked twice before the others.
- Pointer wrap, NUM_REQ=3: grant requester 2, then valids {0,2} → next grant is 0.
- Stalled engine, TIMEOUT_CYCLES=8: active never rises → o_Timeout pulses exactly 7 cycles after entering LAUNCH. Ready=0, Grant=0, ack already given once, next request served normally.
- Active pre-high: i_Tx_Active=1 at LAUNCH entry → Ready stays 1 until active falls and rises again. No early transition to WAIT_DONE.
- Reset mid-WAIT_DONE: reset=1 for one cycle → all outputs 0, ptr=0. Next valid[1] is granted via a scan from 0, with ack the cycle after valid.
